// File: rtl/twp_master.sv
// TWP initiator: serialises one host command into a START/cmd/addr/data frame on SDA
// and collects the slave's read word after a bounded turnaround wait.
module twp_master #(
    parameter int TIMEOUT = 32,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        SCL,
    inout  wire         SDA,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam int MAXV = (TIMEOUT > 16) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                         : ((GAP > 16) ? GAP : 16);
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [3:0] {
        IDLE, START, CMD, ADDR, WDATA, TURN, RDATA, RESP, GAPS
    } state_e;

    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [7:0]    addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   sh_q, sh_d;
    logic          sda_oe_q, sda_oe_d, sda_do_q, sda_do_d;
    logic          scl_q, scl_d, rdy_q, rdy_d, busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
    logic [15:0]   rsp_rdata_q, rsp_rdata_d;
    logic          sda_in;

    assign SDA         = sda_oe_q ? sda_do_q : 1'bz;
    assign sda_in      = SDA;
    assign SCL         = scl_q;
    assign cmd_ready   = rdy_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_to_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            sda_oe_q    <= 1'b0;
            sda_do_q    <= 1'b1;
            scl_q       <= 1'b1;
            rdy_q       <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            sda_oe_q    <= sda_oe_d;
            sda_do_q    <= sda_do_d;
            scl_q       <= scl_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_to_q    <= rsp_to_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        sda_oe_d    = sda_oe_q;
        sda_do_d    = sda_do_q;
        scl_d       = scl_q;
        rsp_valid_d = 1'b0;
        rsp_to_d    = rsp_to_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                write_d  = cmd_write;
                addr_d   = cmd_addr;
                wdata_d  = cmd_wdata;
                sda_oe_d = 1'b1;
                sda_do_d = 1'b0;
                scl_d    = 1'b0;
                state_d  = START;
            end
            START: begin
                sda_do_d = write_q;
                state_d  = CMD;
            end
            CMD: begin
                sda_do_d = addr_q[0];
                cnt_d    = CW'(1);
                state_d  = ADDR;
            end
            ADDR: begin
                if (cnt_q == CW'(8)) begin
                    if (write_q) begin
                        sda_do_d = wdata_q[0];
                        cnt_d    = CW'(1);
                        state_d  = WDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = TURN;
                    end
                end else begin
                    sda_do_d = addr_q[cnt_q[2:0]];
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            WDATA: begin
                if (cnt_q == CW'(16)) begin
                    sda_oe_d    = 1'b0;
                    scl_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    sda_do_d = wdata_q[cnt_q[3:0]];
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            TURN: begin
                // x or z on the line is treated as "no start bit yet"
                if (sda_in == 1'b0) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    scl_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RDATA: begin
                sh_d  = {sda_in, sh_q[15:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(15)) begin
                    scl_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b0;
                    rsp_rdata_d = {sda_in, sh_q[15:1]};
                    state_d     = RESP;
                end
            end
            // The response cycle is the first of the GAP idle cycles
            RESP: begin
                cnt_d   = '0;
                state_d = (GAP == 1) ? IDLE : GAPS;
            end
            GAPS: begin
                if (cnt_q == CW'(GAP - 2)) state_d = IDLE;
                else                      cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_twp_master.sv
// Directed bench for twp_master: write/read frames, timeout, back-to-back, mid-frame
// reset and a loopback through a small behavioural register slave.
module tb_twp_master;
    localparam int TO = 32;
    localparam int GP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    wire         SDA;
    logic        SCL, cmd_ready, rsp_valid, rsp_timeout, busy;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [15:0] rsp_rdata;
    logic        s_oe = 1'b0, s_do = 1'b1;
    logic [15:0] mem [256];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;
    pullup (SDA);
    assign SDA = s_oe ? s_do : 1'bz;

    twp_master #(.TIMEOUT(TO), .GAP(GP)) dut (
        .clk(clk), .reset_n(reset_n), .SCL(SCL), .SDA(SDA),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    // Called at a negedge; returns at the negedge after the accept edge E0.
    task automatic start_cmd(input logic w, input logic [7:0] a, input logic [15:0] d,
                             input bit hold);
        bit ok = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL accept_wait: cmd_ready stayed low"); end
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (SCL !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", SCL); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", rsp_rdata); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", rsp_timeout); end
        checks++; if (dut.sda_oe_q !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", dut.sda_oe_q); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit exp [26] = '{0,1, 0,0,1,1,1,1,0,0, 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1};
        start_cmd(1'b1, 8'h3C, 16'hA5F0, 0);
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (SDA !== exp[i] || dut.sda_oe_q !== 1'b1 || SCL !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL wr_bit E%0d got sda=%b oe=%b scl=%b rdy=%b want sda=%b oe=1 scl=0 rdy=0",
                         i, SDA, dut.sda_oe_q, SCL, cmd_ready, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 16'h0 ||
            dut.sda_oe_q !== 1'b0 || SCL !== 1'b1) begin
            errors++;
            $display("FAIL wr_rsp got v=%b to=%b rd=%h oe=%b scl=%b want v=1 to=0 rd=0000 oe=0 scl=1",
                     rsp_valid, rsp_timeout, rsp_rdata, dut.sda_oe_q, SCL);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL wr_gap1 got v=%b rdy=%b want v=0 rdy=0", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_ready got rdy=%b busy=%b want rdy=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_read();
        bit exp [10] = '{0,0, 1,0,1,0,0,0,0,0};
        logic [15:0] word = 16'h1234;
        int bad = 0;
        start_cmd(1'b0, 8'h05, 16'h0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (SDA !== exp[i] || SCL !== 1'b0) begin
                errors++; $display("FAIL rd_bit E%0d got sda=%b scl=%b want sda=%b scl=0", i, SDA, SCL, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (dut.sda_oe_q !== 1'b0 || SCL !== 1'b0) begin
            errors++; $display("FAIL rd_turn got oe=%b scl=%b want oe=0 scl=0", dut.sda_oe_q, SCL);
        end
        s_oe = 1'b1; s_do = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_do = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_do = word[i];
            if (dut.sda_oe_q !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rd_data_phase got %0d bad cycles want 0", bad); end
        @(negedge clk);
        s_oe = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_timeout !== 1'b0 || SCL !== 1'b1) begin
            errors++;
            $display("FAIL rd_rsp got v=%b rd=%h to=%b scl=%b want v=1 rd=1234 to=0 scl=1",
                     rsp_valid, rsp_rdata, rsp_timeout, SCL);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        start_cmd(1'b0, 8'h5A, 16'h0, 0);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin k = i; break; end
        end
        checks++;
        if (k != 10 + TO) begin errors++; $display("FAIL to_latency got E%0d want E%0d", k, 10 + TO); end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_rdata !== 16'h0 || SCL !== 1'b1) begin
            errors++; $display("FAIL to_rsp got to=%b rd=%h scl=%b want to=1 rd=0000 scl=1",
                               rsp_timeout, rsp_rdata, SCL);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0, rdy_bad = 0, n = 0, drv = 0;
        logic [7:0] a2 = '0;
        start_cmd(1'b1, 8'h12, 16'h0001, 1);
        cmd_addr = 8'h34; cmd_wdata = 16'hBEEF;
        for (int i = 1; i <= 60; i++) begin
            if (cmd_ready !== 1'b0) rdy_bad++;
            @(negedge clk);
            if (rsp_valid === 1'b1) begin k = i; break; end
        end
        checks++;
        if (k != 26 || rdy_bad != 0) begin
            errors++; $display("FAIL b2b_first got rsp@E%0d rdy_bad=%0d want rsp@E26 rdy_bad=0", k, rdy_bad);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (SCL === 1'b0) break;
            if (dut.sda_oe_q !== 1'b0) drv++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n != GP + 1) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", n, GP + 1); end
        checks++;
        if (drv != 0) begin errors++; $display("FAIL b2b_gap_drive got %0d driven cycles want 0", drv); end
        checks++;
        if (SDA !== 1'b0 || dut.sda_oe_q !== 1'b1) begin
            errors++; $display("FAIL b2b_start got sda=%b oe=%b want sda=0 oe=1", SDA, dut.sda_oe_q);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a2[i] = SDA;
        end
        checks++;
        if (a2 !== 8'h34) begin errors++; $display("FAIL b2b_second_addr got %h want 34", a2); end
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin k = 1; break; end
        end
        checks++;
        if (k != 1) begin errors++; $display("FAIL b2b_second_rsp got none want pulse"); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        start_cmd(1'b1, 8'h77, 16'h1234, 0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut.sda_oe_q !== 1'b0 || SCL !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got oe=%b scl=%b rdy=%b want oe=0 scl=1 rdy=1",
                               dut.sda_oe_q, SCL, cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || dut.sda_oe_q !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_no_rsp got %0d bad cycles want 0", bad); end
        start_cmd(1'b1, 8'hFF, 16'hFFFF, 0);
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (SDA !== (i != 0)) begin
                errors++; $display("FAIL ff_bit E%0d got %b want %b", i, SDA, (i != 0));
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL ff_rsp got v=%b to=%b want v=1 to=0", rsp_valid, rsp_timeout);
        end
    endtask

    task automatic test_loopback();
        logic [25:0] cap = '0;
        logic [7:0]  ra;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        start_cmd(1'b1, 8'h80, 16'h0011, 0);
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            cap[i] = SDA;
        end
        if (cap[1] === 1'b1) mem[cap[9:2]] = cap[25:10];
        checks++;
        if (cap[9:2] !== 8'h80 || cap[25:10] !== 16'h0011) begin
            errors++; $display("FAIL lb_wr_frame got a=%h d=%h want a=80 d=0011", cap[9:2], cap[25:10]);
        end
        @(negedge clk);
        start_cmd(1'b0, 8'h80, 16'h0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            cap[i] = SDA;
        end
        ra = cap[9:2];
        @(negedge clk);
        s_oe = 1'b1; s_do = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_do = mem[ra][i];
        end
        @(negedge clk);
        s_oe = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0011 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL lb_rd got v=%b rd=%h to=%b want v=1 rd=0011 to=0",
                               rsp_valid, rsp_rdata, rsp_timeout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
